// File: rtl/seq_det_pkg.sv
// Shared types and reset constants for the programmable sequence detector.
package seq_det_pkg;

  localparam int unsigned DEF_PAT_W = 8;
  localparam int unsigned DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Power-on configuration detects "101", non-overlapping, free-running
  localparam logic [15:0] RST_PATTERN = 16'b101;
  localparam int unsigned RST_LEN     = 3;
  localparam logic        RST_OVERLAP = 1'b0;

endpackage

// File: rtl/seq_match_core.sv
// Serial pattern matcher: shift history, valid-bit fill count and length-masked compare.
module seq_match_core
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = DEF_PAT_W,
  parameter int unsigned LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic             clr,
  input  logic             x,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             overlap,
  output logic             hit
);

  logic [PAT_W-1:0] r_hist;
  logic [LEN_W-1:0] r_fill;
  logic [PAT_W-1:0] w_hist_nxt;
  logic [PAT_W-1:0] w_mask;
  logic [LEN_W-1:0] w_fill_inc;
  logic             w_enough;

  assign w_hist_nxt = {r_hist[PAT_W-2:0], x};
  assign w_fill_inc = (r_fill == LEN_W'(PAT_W)) ? r_fill : r_fill + LEN_W'(1);
  // Compare against the window including the bit being sampled this cycle
  assign w_enough   = ({1'b0, r_fill} + (LEN_W + 1)'(1)) >= {1'b0, len};

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < int'(PAT_W); i++) begin
      w_mask[i] = (i < int'(len));
    end
  end

  assign hit = sample_en & w_enough & (((w_hist_nxt ^ pattern) & w_mask) == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (clr) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (sample_en) begin
      r_hist <= w_hist_nxt;
      // Non-overlap: forget consumed bits so the next match needs a full fresh window
      r_fill <= (hit && !overlap) ? '0 : w_fill_inc;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Sequence-detection controller: config registers, arm/disarm FSM, match counter and outputs.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = DEF_PAT_W,
  parameter int unsigned CNT_W = DEF_CNT_W,
  localparam int unsigned LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             start,
  input  logic             abort,
  input  logic             x,
  input  logic             x_valid,
  output logic             z,
  output logic [CNT_W-1:0] match_count,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [PAT_W-1:0] r_pattern;
  logic [LEN_W-1:0] r_len;
  logic             r_overlap;
  logic [CNT_W-1:0] r_target;
  logic [CNT_W-1:0] r_count;
  logic             r_z;
  logic             r_err;

  logic w_clr;
  logic w_sample_en;
  logic w_hit;
  logic w_final;
  logic w_len_ok;
  logic w_cfg_ok;

  // Abort beats start; a start edge never samples x
  assign w_clr       = start & ~abort;
  assign w_sample_en = (r_state == ARMED) & x_valid & ~start & ~abort;
  assign w_final     = (r_target != '0) && (r_count == r_target - CNT_W'(1));
  assign w_len_ok    = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
  assign w_cfg_ok    = cfg_we && (r_state != ARMED) && w_len_ok;

  seq_match_core #(
    .PAT_W(PAT_W),
    .LEN_W(LEN_W)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .sample_en(w_sample_en),
    .clr      (w_clr),
    .x        (x),
    .pattern  (r_pattern),
    .len      (r_len),
    .overlap  (r_overlap),
    .hit      (w_hit)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = IDLE;
    end else if (start) begin
      w_state_nxt = ARMED;
    end else if (w_hit && w_final) begin
      w_state_nxt = DONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_count <= '0;
      r_z     <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_z     <= w_hit;
      r_err   <= cfg_we && ((r_state == ARMED) || !w_len_ok);
      if (w_clr) begin
        r_count <= '0;
      end else if (w_hit && (r_count != '1)) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pattern <= PAT_W'(RST_PATTERN);
      r_len     <= LEN_W'(RST_LEN);
      r_overlap <= RST_OVERLAP;
      r_target  <= '0;
    end else if (w_cfg_ok) begin
      r_pattern <= cfg_pattern;
      r_len     <= cfg_len;
      r_overlap <= cfg_overlap;
      r_target  <= cfg_target;
    end
  end

  assign z           = r_z;
  assign match_count = r_count;
  assign busy        = (r_state == ARMED);
  assign done        = (r_state == DONE);
  assign err         = r_err;

endmodule
